// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that loads the five PWM configuration registers from 16-bit write frames.
// Pins are synchronised into clk; frame format is {R/W, addr[6:0], data[7:0]}, MSB first.
module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Synchronisers and history are left out of reset so that ncs held low
  // through reset never looks like a fresh falling edge.
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic [2:0]                  r_hist;
  logic [2:0]                  w_pins;

  always_ff @(posedge clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], {ncs, copi, sclk}};
    r_hist <= w_pins;
  end

  assign w_pins = r_sync[SYNC_STAGES-1];

  logic w_sclk_rise, w_copi, w_ncs_fall, w_ncs_rise;
  assign w_sclk_rise = w_pins[0] & ~r_hist[0];
  assign w_copi      = w_pins[1];
  assign w_ncs_fall  = ~w_pins[2] & r_hist[2];
  assign w_ncs_rise  = w_pins[2] & ~r_hist[2];

  state_t      r_state, w_next;
  logic [15:0] r_shift;
  logic [4:0]  r_cnt;
  logic [6:0]  w_addr;
  logic [7:0]  w_data;
  logic        w_wr;

  assign w_addr = r_shift[14:8];
  assign w_data = r_shift[7:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_ncs_fall) w_next = SHIFT;
      SHIFT:   if (w_ncs_rise) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_wr      = 1'b0;
    frame_err = 1'b0;
    if (r_state == COMMIT) begin
      frame_err = (r_cnt != 5'd16);
      w_wr      = (r_cnt == 5'd16) && r_shift[15] && (w_addr <= 7'(MAX_ADDR));
    end
  end

  // An sclk rise coinciding with the ncs rise is still shifted before COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (r_state == IDLE && w_ncs_fall) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (r_state == SHIFT && w_sclk_rise) begin
      r_shift <= {r_shift[14:0], w_copi};
      if (r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;
    end
  end

  logic [4:0][7:0] r_regs;

  always_ff @(posedge clk) begin
    if (rst) r_regs <= '0;
    else if (w_wr) begin
      for (int i = 0; i < 5; i++)
        if (w_addr == 7'(i)) r_regs[i] <= w_data;
    end
  end

  assign en_reg_out_7_0  = r_regs[0];
  assign en_reg_out_15_8 = r_regs[1];
  assign en_reg_pwm_7_0  = r_regs[2];
  assign en_reg_pwm_15_8 = r_regs[3];
  assign pwm_duty_cycle  = r_regs[4];

endmodule
